sync_change_logger: RTL

SYNC_CHANGE_LOGGER -- requirements
Module: sync_change_logger

---
 rtl/sync_change_logger_pkg.sv | 8 +
 rtl/sync_change_logger_fifo.sv | 66 ++++++
 rtl/sync_change_logger.sv | 75 +++++++
 3 files changed

// File: rtl/sync_change_logger_pkg.sv
// Shared defaults for the change logger and its event buffer.
package sync_change_logger_pkg;

  localparam int LCB_WIDTH      = 1;
  localparam int LCB_DEPTH_LOG2 = 2;
  localparam int LCB_TS_WIDTH   = 16;

endpackage

// File: rtl/sync_change_logger_fifo.sv
// Single-clock show-ahead FIFO with an extra port that rewrites the newest entry in place.
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic                  ovw_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] newest_ptr;
  logic                  empty;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign do_rd      = rd_en & ~empty;
  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign do_wr      = wr_en & (~full | do_rd);
  assign newest_ptr = wr_ptr - PTR_ONE;
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end else if (ovw_en && !empty) begin
      mem[newest_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_change_logger.sv
// Logs timestamped value changes of a synchronized word into a small buffer;
// when the buffer is full the newest entry is coalesced so the tail always tracks din.
module sync_change_logger
  import sync_change_logger_pkg::*;
#(
  parameter int WIDTH      = LCB_WIDTH,
  parameter int DEPTH_LOG2 = LCB_DEPTH_LOG2,
  parameter int TS_WIDTH   = LCB_TS_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      din,
  input  logic [WIDTH-1:0]      din_default,
  output logic [WIDTH-1:0]      evt_data,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DATA_W = WIDTH + TS_WIDTH;
  localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [TS_WIDTH-1:0]  TS_ONE   = TS_WIDTH'(1);

  logic [WIDTH-1:0]    prev;
  logic [TS_WIDTH-1:0] ts;
  logic [DATA_W-1:0]   head;
  logic                change;
  logic                pop;
  logic                full;
  logic                push;
  logic                coalesce;

  assign change    = (din != prev);
  // evt_valid comes from the registered count, so evt_ready never loops back into it.
  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign full      = (count == FULL_CNT);
  assign push      = change & (~full | pop);
  assign coalesce  = change & full & ~pop;
  assign {evt_data, evt_ts} = head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev     <= din_default;
      ts       <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= din;
      ts   <= ts + TS_ONE;
      if (coalesce) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  fifo_sync #(
    .DATA_WIDTH (DATA_W),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .ovw_en  (coalesce),
    .wr_data ({din, ts}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

endmodule
